gamemachine_multi: RTL and testbench

GAMEMACHINE_MULTI -- requirements
Module: gamemachine_multi

---
 rtl/gamemachine_pkg.sv | 21 ++
 rtl/gm_slot_classify.sv | 40 ++++
 rtl/gamemachine_multi.sv | 191 +++++++++++++++++++
 tb/tb_gamemachine_multi.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gamemachine_pkg.sv
// Shared types and scoring constants for the two-player code-guessing game.
package gamemachine_pkg;

  typedef enum logic [1:0] {
    SECRET = 2'd0,
    GUESS  = 2'd1,
    SCORE  = 2'd2,
    OVER   = 2'd3
  } gm_state_t;

  typedef enum logic [1:0] {
    ABSENT  = 2'd0,
    PRESENT = 2'd1,
    EXACT   = 2'd2
  } gm_class_t;

  localparam int unsigned PTS_EXACT   = 2;
  localparam int unsigned PTS_PRESENT = 1;
  localparam int unsigned PTS_ABSENT  = 2;

endpackage : gamemachine_pkg

// File: rtl/gm_slot_classify.sv
// Classifies one guess symbol against the whole secret: exact position match,
// present elsewhere (no consumption of secret slots), or absent.
module gm_slot_classify
  import gamemachine_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned SYM_W = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [SLOTS-1:0][SYM_W-1:0] secret,
  input  logic [SYM_W-1:0]            sym,
  input  logic [IDX_W-1:0]            idx,
  output gm_class_t                   cls_c
);

  logic exact_c;
  logic present_c;

  always_comb begin
    exact_c   = 1'b0;
    present_c = 1'b0;
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (IDX_W'(j) == idx) begin
        exact_c = (secret[j] == sym);
      end else if (secret[j] == sym) begin
        present_c = 1'b1;
      end
    end
  end

  always_comb begin
    cls_c = ABSENT;
    if (exact_c) begin
      cls_c = EXACT;
    end else if (present_c) begin
      cls_c = PRESENT;
    end
  end

endmodule : gm_slot_classify

// File: rtl/gamemachine_multi.sv
// Two-player code-guessing game: setter enters a secret, guesser enters a guess,
// slots are scored one per cycle. Optional GM_ROLE_SWAP_EN alternates the setter each round.
module gamemachine_multi
  import gamemachine_pkg::*;
#(
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned ROUNDS  = 1,
  parameter int unsigned SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter1,
  input  logic               enter2,
  input  logic [SYM_W-1:0]   dataIn,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               busy,
  output logic               round_done,
  output logic               game_over
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned ACC_W = $clog2(2 * SLOTS + 1);
  localparam int unsigned SUM_W = SCORE_W + ACC_W;
  localparam int unsigned RND_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOTS - 1);
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  gm_state_t state_q;
  gm_state_t state_d;

  logic [IDX_W-1:0]            idx_q;
  logic [RND_W-1:0]            round_q;
  logic                        e1_q;
  logic                        e2_q;
  logic [SLOTS-1:0][SYM_W-1:0] secret_q;
  logic [SLOTS-1:0][SYM_W-1:0] guess_q;
  logic [ACC_W-1:0]            acc_set_q;
  logic [ACC_W-1:0]            acc_gue_q;
  logic                        commit_q;

  logic             setter_p1_c;
  logic             rise1_c;
  logic             rise2_c;
  logic             set_rise_c;
  logic             gue_rise_c;
  logic             take_c;
  logic             last_idx_c;
  logic [RND_W-1:0] rounds_nxt_c;
  logic             last_round_c;
  gm_class_t        cls_c;
  logic [ACC_W-1:0] pts_set_c;
  logic [ACC_W-1:0] pts_gue_c;
  logic [ACC_W-1:0] tot_set_c;
  logic [ACC_W-1:0] tot_gue_c;
  logic [ACC_W-1:0] pts1_c;
  logic [ACC_W-1:0] pts2_c;
  logic [SUM_W-1:0] sum1_c;
  logic [SUM_W-1:0] sum2_c;
  logic [SCORE_W-1:0] new1_c;
  logic [SCORE_W-1:0] new2_c;

`ifdef GM_ROLE_SWAP_EN
  assign setter_p1_c = ~round_q[0];
`else
  assign setter_p1_c = 1'b1;
`endif

  // Edge detect; simultaneous enters are discarded entirely.
  assign rise1_c    = enter1 & ~e1_q;
  assign rise2_c    = enter2 & ~e2_q;
  assign set_rise_c = setter_p1_c ? rise1_c : rise2_c;
  assign gue_rise_c = setter_p1_c ? rise2_c : rise1_c;
  assign take_c     = ~(enter1 & enter2) &
                      (((state_q == SECRET) & set_rise_c) |
                       ((state_q == GUESS)  & gue_rise_c));

  assign last_idx_c   = (idx_q == LAST_IDX);
  assign rounds_nxt_c = round_q + RND_W'(1);
  assign last_round_c = (32'(rounds_nxt_c) >= ROUNDS);

  gm_slot_classify #(
    .SLOTS (SLOTS),
    .SYM_W (SYM_W),
    .IDX_W (IDX_W)
  ) u_classify (
    .secret (secret_q),
    .sym    (guess_q[idx_q]),
    .idx    (idx_q),
    .cls_c  (cls_c)
  );

  always_comb begin
    pts_set_c = '0;
    pts_gue_c = '0;
    case (cls_c)
      EXACT:   pts_gue_c = ACC_W'(PTS_EXACT);
      PRESENT: begin
        pts_gue_c = ACC_W'(PTS_PRESENT);
        pts_set_c = ACC_W'(PTS_PRESENT);
      end
      default: pts_set_c = ACC_W'(PTS_ABSENT);
    endcase
  end

  // Round totals including the slot being evaluated this cycle, mapped onto players.
  always_comb begin
    tot_set_c = acc_set_q + pts_set_c;
    tot_gue_c = acc_gue_q + pts_gue_c;
    pts1_c    = setter_p1_c ? tot_set_c : tot_gue_c;
    pts2_c    = setter_p1_c ? tot_gue_c : tot_set_c;
    sum1_c    = SUM_W'(score1) + SUM_W'(pts1_c);
    sum2_c    = SUM_W'(score2) + SUM_W'(pts2_c);
    new1_c    = (sum1_c > SCORE_MAX) ? {SCORE_W{1'b1}} : SCORE_W'(sum1_c);
    new2_c    = (sum2_c > SCORE_MAX) ? {SCORE_W{1'b1}} : SCORE_W'(sum2_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SECRET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SECRET: if (take_c && last_idx_c) state_d = GUESS;
      GUESS:  if (take_c && last_idx_c) state_d = SCORE;
      SCORE:  if (last_idx_c) state_d = last_round_c ? OVER : SECRET;
      default: state_d = OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q      <= '0;
      round_q    <= '0;
      e1_q       <= 1'b0;
      e2_q       <= 1'b0;
      secret_q   <= '0;
      guess_q    <= '0;
      acc_set_q  <= '0;
      acc_gue_q  <= '0;
      commit_q   <= 1'b0;
      score1     <= '0;
      score2     <= '0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      e1_q       <= enter1;
      e2_q       <= enter2;
      commit_q   <= 1'b0;
      round_done <= commit_q;
      busy       <= (state_d == SCORE);
      case (state_q)
        SECRET, GUESS: begin
          if (take_c) begin
            if (state_q == SECRET) begin
              secret_q[idx_q] <= dataIn;
            end else begin
              guess_q[idx_q] <= dataIn;
            end
            idx_q <= last_idx_c ? '0 : idx_q + IDX_W'(1);
          end
        end
        SCORE: begin
          if (last_idx_c) begin
            idx_q     <= '0;
            acc_set_q <= '0;
            acc_gue_q <= '0;
            score1    <= new1_c;
            score2    <= new2_c;
            commit_q  <= 1'b1;
            round_q   <= rounds_nxt_c;
            game_over <= last_round_c;
          end else begin
            idx_q     <= idx_q + IDX_W'(1);
            acc_set_q <= tot_set_c;
            acc_gue_q <= tot_gue_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : gamemachine_multi

// File: tb/tb_gamemachine_multi.sv
// Directed bench for gamemachine_multi: one ROUNDS=1 instance and one ROUNDS=3 instance
// sharing the enter/data inputs; the idle instance is held in reset.
module tb_gamemachine_multi;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       enter1, enter2;
  logic [2:0] din;
  logic [3:0] s1a, s2a, s1b, s2b;
  logic       busy_a, rd_a, go_a, busy_b, rd_b, go_b;
  logic       sel_b;
  logic [3:0] s1, s2;
  logic       busy, rd, go;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  gamemachine_multi #(.SLOTS(4), .SYM_W(3), .ROUNDS(1), .SCORE_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .enter1(enter1), .enter2(enter2), .dataIn(din),
    .score1(s1a), .score2(s2a), .busy(busy_a), .round_done(rd_a), .game_over(go_a)
  );

  gamemachine_multi #(.SLOTS(4), .SYM_W(3), .ROUNDS(3), .SCORE_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .enter1(enter1), .enter2(enter2), .dataIn(din),
    .score1(s1b), .score2(s2b), .busy(busy_b), .round_done(rd_b), .game_over(go_b)
  );

  assign s1   = sel_b ? s1b : s1a;
  assign s2   = sel_b ? s2b : s2a;
  assign busy = sel_b ? busy_b : busy_a;
  assign rd   = sel_b ? rd_b : rd_a;
  assign go   = sel_b ? go_b : go_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic press(input bit p1, input logic [2:0] d);
    @(negedge clk);
    din = d;
    if (p1) enter1 = 1'b1; else enter2 = 1'b1;
    @(negedge clk);
    enter1 = 1'b0;
    enter2 = 1'b0;
  endtask

  task automatic load_round(input bit p1_sets, input logic [11:0] s, input logic [11:0] g);
    for (int i = 0; i < 4; i++) press(p1_sets, s[i*3 +: 3]);
    for (int i = 0; i < 4; i++) press(!p1_sets, g[i*3 +: 3]);
  endtask

  // Entered just after the last guess capture edge (E0); leaves after E6.
  task automatic finish_round(input string tag, input int prev1, input int prev2,
                              input int exp1, input int exp2);
    check({tag, ".busy_e0"}, 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, ".s1_e3"}, 32'(s1), 32'(prev1));
    check({tag, ".s2_e3"}, 32'(s2), 32'(prev2));
    @(negedge clk);
    check({tag, ".s1"}, 32'(s1), 32'(exp1));
    check({tag, ".s2"}, 32'(s2), 32'(exp2));
    check({tag, ".busy_e4"}, 32'(busy), 32'd0);
    check({tag, ".rd_e4"}, 32'(rd), 32'd0);
    @(negedge clk);
    check({tag, ".rd_e5"}, 32'(rd), 32'd1);
    @(negedge clk);
    check({tag, ".rd_e6"}, 32'(rd), 32'd0);
  endtask

  task automatic run_round(input string tag, input bit p1_sets, input logic [11:0] s,
                           input logic [11:0] g, input int prev1, input int prev2,
                           input int exp1, input int exp2);
    load_round(p1_sets, s, g);
    finish_round(tag, prev1, prev2, exp1, exp2);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic over_ignored(input string tag, input int exp1, input int exp2);
    press(1'b1, 3'd1);
    press(1'b0, 3'd2);
    press(1'b1, 3'd3);
    press(1'b0, 3'd4);
    repeat (6) begin
      @(negedge clk);
      check({tag, ".rd"}, 32'(rd), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
    end
    check({tag, ".s1"}, 32'(s1), 32'(exp1));
    check({tag, ".s2"}, 32'(s2), 32'(exp2));
    check({tag, ".go"}, 32'(go), 32'd1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; enter1 = 1'b0; enter2 = 1'b0; din = '0; sel_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.s1", 32'(s1), 32'd0);
    check("rst.s2", 32'(s2), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rd", 32'(rd), 32'd0);
    check("rst.go", 32'(go), 32'd0);
    rst_a = 1'b1;

    run_round("r_0124", 1'b1, pk(0,1,2,3), pk(0,1,2,4), 0, 0, 2, 6);
    check("r_0124.go", 32'(go), 32'd1);
    reset_a();
    check("rst2.go", 32'(go), 32'd0);
    check("rst2.s1", 32'(s1), 32'd0);
    run_round("r_1043", 1'b1, pk(0,1,2,3), pk(1,0,4,3), 0, 0, 4, 4);
    reset_a();
    run_round("r_4567", 1'b1, pk(0,1,2,3), pk(4,5,6,7), 0, 0, 8, 0);
    reset_a();
    run_round("r_0025", 1'b1, pk(0,1,2,3), pk(0,0,2,5), 0, 0, 3, 5);
    reset_a();

    // Ignored/duplicate enters during SECRET.
    press(1'b0, 3'd5);
    @(negedge clk);
    din = 3'd0; enter1 = 1'b1;
    repeat (3) @(negedge clk);
    enter1 = 1'b0;
    @(negedge clk);
    din = 3'd7; enter1 = 1'b1; enter2 = 1'b1;
    @(negedge clk);
    enter1 = 1'b0; enter2 = 1'b0;
    press(1'b1, 3'd1);
    press(1'b1, 3'd2);
    press(1'b1, 3'd3);
    press(1'b0, 3'd0);
    press(1'b0, 3'd1);
    press(1'b0, 3'd2);
    check("edge.busy_pre", 32'(busy), 32'd0);
    press(1'b0, 3'd3);
    finish_round("edge", 0, 0, 0, 8);
    reset_a();

    // Reset in the middle of SCORE.
    load_round(1'b1, pk(0,1,2,3), pk(0,1,2,3));
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    check("midrst.s1", 32'(s1), 32'd0);
    check("midrst.s2", 32'(s2), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("midrst.rd", 32'(rd), 32'd0);
      check("midrst.s2_hold", 32'(s2), 32'd0);
    end
    run_round("post_rst", 1'b1, pk(0,1,2,3), pk(4,5,6,7), 0, 0, 8, 0);

    // Multi-round instance.
    @(negedge clk);
    rst_a = 1'b0;
    sel_b = 1'b1;
    rst_b = 1'b1;
`ifdef GM_ROLE_SWAP_EN
    run_round("swap1", 1'b1, pk(0,1,2,3), pk(0,1,2,3), 0, 0, 0, 8);
    check("swap1.go", 32'(go), 32'd0);
    run_round("swap2", 1'b0, pk(0,1,2,3), pk(0,1,2,3), 0, 8, 8, 8);
    check("swap2.go", 32'(go), 32'd0);
    run_round("swap3", 1'b1, pk(0,1,2,3), pk(4,5,6,7), 8, 8, 15, 8);
    check("swap3.go", 32'(go), 32'd1);
    over_ignored("swap_over", 15, 8);
`else
    run_round("sat1", 1'b1, pk(0,1,2,3), pk(0,1,2,3), 0, 0, 0, 8);
    check("sat1.go", 32'(go), 32'd0);
    run_round("sat2", 1'b1, pk(7,6,5,4), pk(7,6,5,4), 0, 8, 0, 15);
    check("sat2.go", 32'(go), 32'd0);
    run_round("sat3", 1'b1, pk(1,1,2,2), pk(1,1,2,2), 0, 15, 0, 15);
    check("sat3.go", 32'(go), 32'd1);
    over_ignored("over", 0, 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gamemachine_multi
